// File: rtl/branch_predictor_bht_if.sv
// Lookup/update bundle between the IF/EX pipeline (master) and the branch history table (slave).
interface branch_predictor_bht_if #(
    parameter int IDX_W = 3,
    parameter int CNT_W = 16
);
    logic [IDX_W-1:0] ADDR;
    logic             PREDICTION;
    logic [IDX_W-1:0] PRED_IDX;
    logic             UPDATE_VALID;
    logic [IDX_W-1:0] UPDATE_IDX;
    logic             UPDATE_TAKEN;
    logic             UPDATE_PRED;
    logic [CNT_W-1:0] BRANCHES;
    logic [CNT_W-1:0] MISSES;

    modport master (
        output ADDR, UPDATE_VALID, UPDATE_IDX, UPDATE_TAKEN, UPDATE_PRED,
        input  PREDICTION, PRED_IDX, BRANCHES, MISSES
    );

    modport slave (
        input  ADDR, UPDATE_VALID, UPDATE_IDX, UPDATE_TAKEN, UPDATE_PRED,
        output PREDICTION, PRED_IDX, BRANCHES, MISSES
    );
endinterface

// File: rtl/branch_predictor_bht.sv
// Branch history table of saturating counters with combinational lookup and registered training.
// Optional gshare indexing (global history xor address) is enabled with macro GSHARE_EN.
module branch_predictor_bht #(
    parameter int IDX_W = 3,
    parameter int CTR_W = 2,
    parameter int CNT_W = 16
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    branch_predictor_bht_if.slave bus
);
    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((2 ** (CTR_W - 1)) - 1);

    function automatic logic [CTR_W-1:0] sat_inc_ctr(input logic [CTR_W-1:0] c);
        return (c == {CTR_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    function automatic logic [CTR_W-1:0] sat_dec_ctr(input logic [CTR_W-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    logic [CTR_W-1:0] bht_q [DEPTH];
    logic [CTR_W-1:0] ctr_d;
    logic [CNT_W-1:0] branches_q, branches_d;
    logic [CNT_W-1:0] misses_q, misses_d;
    logic [IDX_W-1:0] pred_idx;

`ifdef GSHARE_EN
    logic [IDX_W-1:0] ghr_q, ghr_d;

    assign ghr_d    = {ghr_q[IDX_W-2:0], bus.UPDATE_TAKEN};
    assign pred_idx = bus.ADDR ^ ghr_q;

    // History shifts only on resolved branches; lookups never speculate into it.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            ghr_q <= '0;
        end else if (bus.UPDATE_VALID) begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign pred_idx = bus.ADDR;
`endif

    // Lookup reads the registered table, so a same-cycle update is not bypassed.
    assign bus.PRED_IDX   = pred_idx;
    assign bus.PREDICTION = bht_q[pred_idx][CTR_W-1];
    assign bus.BRANCHES   = branches_q;
    assign bus.MISSES     = misses_q;

    always_comb begin
        ctr_d      = bus.UPDATE_TAKEN ? sat_inc_ctr(bht_q[bus.UPDATE_IDX])
                                      : sat_dec_ctr(bht_q[bus.UPDATE_IDX]);
        branches_d = sat_inc_cnt(branches_q);
        misses_d   = (bus.UPDATE_TAKEN != bus.UPDATE_PRED) ? sat_inc_cnt(misses_q) : misses_q;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                bht_q[i] <= CTR_INIT;
            end
            branches_q <= '0;
            misses_q   <= '0;
        end else if (bus.UPDATE_VALID) begin
            bht_q[bus.UPDATE_IDX] <= ctr_d;
            branches_q            <= branches_d;
            misses_q              <= misses_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Randomized and directed bench for branch_predictor_bht against an array-based reference model.
module tb_branch_predictor_bht;
    localparam int IDX_W = 3;
    localparam int CTR_W = 2;
    localparam int CNT_W = 4;
    localparam int DEPTH = 8;
    localparam int CMAX  = 3;
    localparam int SMAX  = 15;

    logic clk;
    logic rst;

    branch_predictor_bht_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bif ();

    branch_predictor_bht #(.IDX_W(IDX_W), .CTR_W(CTR_W), .CNT_W(CNT_W)) dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    int m_ctr [DEPTH];
    int m_br;
    int m_ms;
    int m_ghr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int m_idx(input int a);
`ifdef GSHARE_EN
        return a ^ m_ghr;
`else
        return a;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_ctr[i] = 1;
        m_br  = 0;
        m_ms  = 0;
        m_ghr = 0;
    endtask

    task automatic model_update(input int ui, input int t, input int p);
        if (t != 0) m_ctr[ui] = (m_ctr[ui] < CMAX) ? m_ctr[ui] + 1 : CMAX;
        else        m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
        if (m_br < SMAX) m_br = m_br + 1;
        if (t != p && m_ms < SMAX) m_ms = m_ms + 1;
        m_ghr = (m_ghr * 2 + t) % DEPTH;
    endtask

    task automatic check_outputs(input string tag);
        int ei;
        ei = m_idx(int'(bif.ADDR));
        chk({tag, ".pred_idx"}, 32'(bif.PRED_IDX), 32'(ei));
        chk({tag, ".prediction"}, 32'(bif.PREDICTION), (m_ctr[ei] >= 2) ? 32'd1 : 32'd0);
        chk({tag, ".branches"}, 32'(bif.BRANCHES), 32'(m_br));
        chk({tag, ".misses"}, 32'(bif.MISSES), 32'(m_ms));
    endtask

    // Called at posedge+1; drives one cycle, checks pre-edge outputs, clocks, advances model.
    task automatic step(input int a, input int v, input int ui, input int t, input int p,
                        input string tag);
        bif.ADDR         = IDX_W'(a);
        bif.UPDATE_VALID = (v != 0);
        bif.UPDATE_IDX   = IDX_W'(ui);
        bif.UPDATE_TAKEN = (t != 0);
        bif.UPDATE_PRED  = (p != 0);
        #1;
        check_outputs(tag);
        @(posedge clk);
        if (v != 0) model_update(ui, t, p);
        #1;
    endtask

    // Asserts reset asynchronously, leaving any pending update on the bus so it must be dropped.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        chk({tag, ".async_branches"}, 32'(bif.BRANCHES), 32'd0);
        chk({tag, ".async_misses"}, 32'(bif.MISSES), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bif.UPDATE_VALID = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bif.ADDR = '0;
        bif.UPDATE_VALID = 1'b0;
        bif.UPDATE_IDX = '0;
        bif.UPDATE_TAKEN = 1'b0;
        bif.UPDATE_PRED = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset("rst0");

        for (int a = 0; a < DEPTH; a++) step(a, 0, 0, 0, 0, "reset_defaults");

        // Saturating training on entry 1, then back down to weakly not-taken.
        step(1, 1, 1, 1, 0, "train1");
        step(1, 1, 1, 1, 1, "train2");
        step(1, 1, 1, 1, 1, "train3");
        step(1, 0, 0, 0, 0, "train_look");
        chk("train.branches", 32'(bif.BRANCHES), 32'd3);
        chk("train.misses", 32'(bif.MISSES), 32'd1);
        step(1, 1, 1, 0, 1, "untrain1");
        step(1, 1, 1, 0, 1, "untrain2");
        step(1, 0, 0, 0, 0, "untrain_look");

        // Index isolation.
        do_reset("rst_iso");
        step(1, 1, 1, 1, 0, "iso_t1");
        step(1, 1, 1, 1, 1, "iso_t2");
        step(2, 1, 2, 0, 0, "iso_nt");
        for (int a = 0; a < DEPTH; a++) step(a, 0, 0, 0, 0, "iso_look");

        // Same-cycle lookup and update: old value seen, new value on the next cycle.
        do_reset("rst_haz");
        step(3, 1, 3, 1, 0, "hazard_same");
        step(3, 0, 0, 0, 0, "hazard_next");

        // Back-to-back increments from weakly not-taken reach strongly taken.
        do_reset("rst_b2b");
        step(4, 1, 4, 1, 0, "b2b1");
        step(4, 1, 4, 1, 1, "b2b2");
        step(4, 1, 4, 0, 1, "b2b_dec");
        step(4, 0, 0, 0, 0, "b2b_look");

        // Statistics saturation.
        do_reset("rst_sat");
        for (int i = 0; i < 20; i++) step(5, 1, 5, 1, 0, "sat_miss");
        step(0, 0, 0, 0, 0, "sat_hold");
        chk("sat.branches", 32'(bif.BRANCHES), 32'd15);
        chk("sat.misses", 32'(bif.MISSES), 32'd15);

        // MISSES keeps counting once BRANCHES is pinned.
        do_reset("rst_sat2");
        for (int i = 0; i < 16; i++) step(6, 1, 6, 0, 0, "sat_hit");
        for (int i = 0; i < 3; i++) step(6, 1, 6, 1, 0, "sat_late_miss");
        step(0, 0, 0, 0, 0, "sat2_hold");
        chk("sat2.branches", 32'(bif.BRANCHES), 32'd15);
        chk("sat2.misses", 32'(bif.MISSES), 32'd3);

        // History sequence taken, not-taken, taken; then reset mid-stream with an update pending.
        do_reset("rst_ghr");
        step(0, 1, 0, 1, 1, "ghr1");
        step(0, 1, 0, 0, 0, "ghr2");
        step(0, 1, 0, 1, 1, "ghr3");
        step(1, 0, 0, 0, 0, "ghr_look");
        bif.UPDATE_VALID = 1'b1;
        bif.UPDATE_IDX   = 3'd1;
        bif.UPDATE_TAKEN = 1'b1;
        do_reset("rst_mid");
        step(1, 0, 0, 0, 0, "post_rst_look");
        step(1, 1, 1, 1, 0, "post_rst_first");
        step(1, 0, 0, 0, 0, "post_rst_after");

        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                bif.UPDATE_VALID = 1'b1;
                do_reset("rnd_rst");
            end else begin
                step(int'($urandom_range(0, DEPTH - 1)), ($urandom_range(0, 9) < 7) ? 1 : 0,
                     int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 1)), "rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Parametrised branch history table of N-bit saturating counters with separate lookup and update ports, for the RV32IM pipeline front end. IF issues a lookup each cycle and receives a combinational taken/not-taken prediction plus the table index used. EX returns the resolved outcome through the update port one or more cycles later. The block trains the table and keeps saturating branch and misprediction statistics.

## Interface
- IDX_W, 3: table index width; table depth = 2^IDX_W entries.
- CTR_W, 2: counter width per entry, legal 1..4.
- CNT_W, 16: width of the BRANCHES and MISSES statistics counters.
- CLOCK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ADDR  input  IDX_W  lookup address bits (PC slice) from IF.
- PREDICTION  output  1  predicted taken (1) / not taken (0) for ADDR.
- PRED_IDX  output  IDX_W  table index used for this lookup; carried down the pipeline.
- UPDATE_VALID  input  1  a branch resolved this cycle.
- UPDATE_IDX  input  IDX_W  PRED_IDX captured at lookup time.
- UPDATE_TAKEN  input  1  resolved outcome.
- UPDATE_PRED  input  1  prediction originally made for this branch.
- BRANCHES  output  CNT_W  resolved-branch count.
- MISSES  output  CNT_W  misprediction count.

## Operation
- Table: 2^IDX_W counters of CTR_W bits. PREDICTION = MSB of entry[PRED_IDX].
- Reset value of every entry: weakly not-taken, 2^(CTR_W-1)-1. For CTR_W=2 this is 01; for CTR_W=1 it is 0.
- Counter training on UPDATE_VALID:
  - UPDATE_TAKEN=1: entry[UPDATE_IDX] increments, saturating at 2^CTR_W-1.
  - UPDATE_TAKEN=0: entry decrements, saturating at 0.
- Statistics on UPDATE_VALID:
  - BRANCHES increments.
  - MISSES increments when UPDATE_TAKEN != UPDATE_PRED.
  - Both saturate at 2^CNT_W-1 and never wrap. MISSES still increments when BRANCHES is already saturated.
- UPDATE_VALID=0: table, statistics and history hold.
- Index hashing is selected by configuration; see Configuration.
- No speculative update. The table and history change only through the update port.

## Timing
- Lookup: zero latency, purely combinational from ADDR (and the history register when enabled) to PREDICTION/PRED_IDX.
- Update: write takes effect at the rising edge where UPDATE_VALID=1. It is visible to lookups from the next cycle.
- Same-cycle lookup and update to the same index: PREDICTION reflects the pre-update value. There is no bypass.
- Back-to-back updates to the same index on consecutive cycles each apply; two increments from 01 give 11.
- At most one update per cycle.
- Reset output values:
  - PREDICTION=0 (all entries weakly not-taken).
  - BRANCHES=0, MISSES=0.
  - History register = 0.
- Reset mid-operation: asserting RESET clears all state immediately, regardless of UPDATE_VALID. An update present at the edge where RESET is high is discarded.
- On RESET deassertion, the first update is taken at the following rising edge.

## Configuration
- GSHARE_EN defined:
  - Block holds an IDX_W-bit global history register GHR, reset 0.
  - PRED_IDX = ADDR xor GHR.
  - On each UPDATE_VALID edge, GHR <= {GHR[IDX_W-2:0], UPDATE_TAKEN}.
  - UPDATE_IDX is used as supplied and is not rehashed.
- GSHARE_EN undefined:
  - No history register.
  - PRED_IDX = ADDR; the block is a plain per-address bimodal table.

## Test plan
- Reset defaults: RESET pulse, ADDR=0..7 -> PREDICTION=0 everywhere, PRED_IDX=ADDR (bimodal build), BRANCHES=0, MISSES=0.
- Saturating training, CTR_W=2, idx 1: updates taken,taken,taken with UPDATE_PRED=0,1,1 -> entry 01→10→11→11, PREDICTION=1 after the first, MISSES=1, BRANCHES=3; then two not-taken -> entry 01, PREDICTION=0.
- Index isolation: train idx 1 to 11, update idx 2 not-taken -> idx 2 at 00, idx 1 still predicts 1.
- Same-cycle hazard: idx 3 at 01, lookup and taken-update to idx 3 in the same cycle -> PREDICTION=0 that cycle, 1 the next.
- Statistics saturation with CNT_W=4: 20 mispredicted updates -> MISSES=15, BRANCHES=15, both holding at 15.
- GSHARE_EN build: updates taken,not-taken,taken -> GHR=101; lookup ADDR=001 -> PRED_IDX=100. RESET mid-sequence -> GHR=0 and PRED_IDX=ADDR.
